// File: rtl/alu_pkg.sv
// Shared types for the ALU execute/writeback stage: control codes,
// the idle result value and the FIFO entry layout.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int ROB_W  = 3;
    localparam int CODE_W = 4;

    // ALU control codes as issued by the reservation station
    typedef enum logic [CODE_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASS2 = 4'd10
    } alu_op_e;

    // Result produced by unused control codes
    localparam logic [DATA_W-1:0] ALU_NOP = '0;

    // One buffered result waiting for the common data bus
    typedef struct packed {
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] result;
    } result_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Small circular FIFO holding ALU results until the common data bus
// accepts them. A push while full is only taken when a pop frees the slot.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = result_entry_t
) (
    input  logic                     clk,
    input  logic                     globalReset,
    input  logic                     clear,
    input  logic                     push,
    input  entry_t                   pushEntry,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output entry_t                   head,
    output logic                     full
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    entry_t             mem_q [DEPTH];
    logic [PW-1:0]      wrPtr_q;
    logic [PW-1:0]      rdPtr_q;
    logic [CNT_W-1:0]   count_q;
    logic               flush;
    logic               doPush;
    logic               doPop;

    assign flush  = globalReset | clear;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign doPop  = pop & (count_q != '0);
    assign doPush = push & (~full | doPop);
    assign count  = count_q;
    assign head   = mem_q[rdPtr_q];

    // Pointer and occupancy bookkeeping; flush empties the queue
    always_ff @(posedge clk) begin
        if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage is not reset; the count decides what is valid
    always_ff @(posedge clk) begin
        if (!flush && doPush) begin
            mem_q[wrPtr_q] <= pushEntry;
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: computes the ALU result for an issued
// instruction, buffers it with its ROB tag, and arbitrates for the
// common data bus while back-pressuring the reservation station.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int C_WIDTH = 3,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   globalReset,
    input  logic                   clear,
    input  logic                   issueValid,
    input  logic signed [WIDTH:0]  src1,
    input  logic signed [WIDTH:0]  src2,
    input  logic [C_WIDTH:0]       instrInfo,
    input  logic [ROB:0]           instrRob,
    output logic                   execute,
    output logic                   cdbReq,
    input  logic                   cdbGrant,
    output logic signed [WIDTH:0]  cdbResult,
    output logic [ROB:0]           cdbRob,
    output logic                   overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic signed [WIDTH:0] aluResult;
    logic [4:0]            shamt;
    result_entry_t         pushEntry;
    result_entry_t         headEntry;
    logic [CNT_W-1:0]      fifoCount;
    logic [CNT_W-1:0]      nextCount;
    logic                  fifoFull;
    logic                  popFire;
    logic                  flush;
    logic                  overflow_q;
    logic                  overflow_d;

    assign flush = globalReset | clear;
    assign shamt = src2[4:0];

    // Combinational ALU on the issued operands; unused codes give ALU_NOP
    always_comb begin
        aluResult = ALU_NOP;
        case (instrInfo)
            ALU_ADD:   aluResult = src1 + src2;
            ALU_SUB:   aluResult = src1 - src2;
            ALU_AND:   aluResult = src1 & src2;
            ALU_OR:    aluResult = src1 | src2;
            ALU_XOR:   aluResult = src1 ^ src2;
            ALU_SLL:   aluResult = src1 << shamt;
            ALU_SRL:   aluResult = $signed($unsigned(src1) >> shamt);
            ALU_SRA:   aluResult = src1 >>> shamt;
            ALU_SLT:   aluResult = {{WIDTH{1'b0}}, (src1 < src2)};
            ALU_SLTU:  aluResult = {{WIDTH{1'b0}}, ($unsigned(src1) < $unsigned(src2))};
            ALU_PASS2: aluResult = src2;
            default:   aluResult = ALU_NOP;
        endcase
    end

    assign pushEntry.rob    = instrRob;
    assign pushEntry.result = aluResult;

    assign cdbReq  = (fifoCount != '0);
    assign popFire = cdbReq & cdbGrant;

    alu_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (result_entry_t)
    ) resultFifo (
        .clk         (clk),
        .globalReset (globalReset),
        .clear       (clear),
        .push        (issueValid),
        .pushEntry   (pushEntry),
        .pop         (popFire),
        .count       (fifoCount),
        .head        (headEntry),
        .full        (fifoFull)
    );

    // Outputs read zero while the FIFO is empty so stale storage never shows
    assign cdbResult = cdbReq ? $signed(headEntry.result) : '0;
    assign cdbRob    = cdbReq ? headEntry.rob : '0;

    // Occupancy after this edge decides whether the station may issue again
    assign nextCount = fifoCount + CNT_W'(issueValid) - CNT_W'(popFire);
    assign execute   = ~flush & (nextCount < CNT_W'(DEPTH));

    // A push into a full FIFO with no pop freeing a slot is lost
    assign overflow_d = overflow_q | (issueValid & fifoFull & ~popFire);

    // Sticky overflow flag, cleared only by reset or flush
    always_ff @(posedge clk) begin
        if (flush) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage with hand-computed expectations.
module tb_alu_writeback_stage;

    logic               clk = 1'b0;
    logic               globalReset;
    logic               clear;
    logic               issueValid;
    logic signed [31:0] src1;
    logic signed [31:0] src2;
    logic [3:0]         instrInfo;
    logic [2:0]         instrRob;
    logic               execute;
    logic               cdbReq;
    logic               cdbGrant;
    logic signed [31:0] cdbResult;
    logic [2:0]         cdbRob;
    logic               overflow;

    int vectors     = 0;
    int miscompares = 0;

    alu_writeback_stage dut (
        .clk         (clk),
        .globalReset (globalReset),
        .clear       (clear),
        .issueValid  (issueValid),
        .src1        (src1),
        .src2        (src2),
        .instrInfo   (instrInfo),
        .instrRob    (instrRob),
        .execute     (execute),
        .cdbReq      (cdbReq),
        .cdbGrant    (cdbGrant),
        .cdbResult   (cdbResult),
        .cdbRob      (cdbRob),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rob);
        issueValid = 1'b1;
        instrInfo  = code;
        src1       = a;
        src2       = b;
        instrRob   = rob;
    endtask

    task automatic runOp(input string tag, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rob, input logic [31:0] expected);
        applyStimulus(code, a, b, rob);
        cdbGrant = 1'b1;
        tick();
        issueValid = 1'b0;
        #1;
        checkOutput({tag, "_req"}, cdbReq, 1);
        checkOutput({tag, "_res"}, cdbResult, expected);
        checkOutput({tag, "_rob"}, cdbRob, rob);
        tick();
    endtask

    initial begin
        globalReset = 1'b1;
        clear       = 1'b0;
        issueValid  = 1'b0;
        src1        = '0;
        src2        = '0;
        instrInfo   = '0;
        instrRob    = '0;
        cdbGrant    = 1'b0;
        #2;
        checkOutput("exec_in_reset", execute, 0);
        tick();
        tick();
        globalReset = 1'b0;
        #1;
        checkOutput("rst_req", cdbReq, 0);
        checkOutput("rst_rob", cdbRob, 0);
        checkOutput("rst_res", cdbResult, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_exec", execute, 1);

        // single ADD with grant held high from the issue cycle
        applyStimulus(4'd0, 32'd7, -32'sd3, 3'd5);
        cdbGrant = 1'b1;
        tick();
        issueValid = 1'b0;
        #1;
        checkOutput("add_req", cdbReq, 1);
        checkOutput("add_res", cdbResult, 32'd4);
        checkOutput("add_rob", cdbRob, 5);
        tick();
        checkOutput("add_drained", cdbReq, 0);

        // operation coverage
        runOp("sub",   4'd1,  32'h80000000, 32'd1,        3'd1, 32'h7FFFFFFF);
        runOp("sra",   4'd7,  32'hF0000000, 32'd4,        3'd2, 32'hFF000000);
        runOp("sltu",  4'd9,  32'd1,        32'hFFFFFFFF, 3'd3, 32'd1);
        runOp("slt",   4'd8,  32'd1,        32'hFFFFFFFF, 3'd4, 32'd0);
        runOp("nop13", 4'd13, 32'h12345678, 32'h9ABCDEF0, 3'd6, 32'd0);
        runOp("xor",   4'd4,  32'hFF00FF00, 32'h0F0F0F0F, 3'd7, 32'hF00FF00F);
        runOp("sll",   4'd5,  32'd1,        32'h0000003F, 3'd0, 32'h80000000);
        runOp("srl",   4'd6,  32'hF0000000, 32'd4,        3'd1, 32'h0F000000);
        runOp("pass2", 4'd10, 32'hDEADBEEF, 32'h12345678, 3'd2, 32'h12345678);
        runOp("addwr", 4'd0,  32'hFFFFFFFF, 32'd2,        3'd3, 32'd1);
        runOp("and",   4'd2,  32'h0000F0F0, 32'h0000FF00, 3'd4, 32'h0000F000);
        runOp("or",    4'd3,  32'h0000F0F0, 32'h0000FF00, 3'd5, 32'h0000FFF0);

        // backpressure: fill two entries with no grant
        cdbGrant = 1'b0;
        applyStimulus(4'd0, 32'd1, 32'd0, 3'd1);
        tick();
        applyStimulus(4'd0, 32'd2, 32'd0, 3'd2);
        #1;
        checkOutput("bp_exec_pending", execute, 0);
        tick();
        issueValid = 1'b0;
        #1;
        checkOutput("bp_full_exec", execute, 0);
        checkOutput("bp_full_ovf", overflow, 0);
        checkOutput("bp_head_rob1", cdbRob, 1);
        checkOutput("bp_head_res1", cdbResult, 1);
        cdbGrant = 1'b1;
        #1;
        checkOutput("bp_grant_exec", execute, 1);
        tick();
        cdbGrant = 1'b0;
        #1;
        checkOutput("bp_head_rob2", cdbRob, 2);
        checkOutput("bp_head_res2", cdbResult, 2);
        checkOutput("bp_exec_back", execute, 1);

        // full with simultaneous push and pop
        applyStimulus(4'd0, 32'd3, 32'd0, 3'd3);
        tick();
        applyStimulus(4'd0, 32'd4, 32'd0, 3'd4);
        cdbGrant = 1'b1;
        #1;
        checkOutput("pp_exec", execute, 0);
        tick();
        issueValid = 1'b0;
        cdbGrant   = 1'b0;
        #1;
        checkOutput("pp_head_rob3", cdbRob, 3);
        checkOutput("pp_still_full", execute, 0);
        checkOutput("pp_ovf", overflow, 0);
        cdbGrant = 1'b1;
        tick();
        cdbGrant = 1'b0;
        #1;
        checkOutput("pp_head_rob4", cdbRob, 4);
        checkOutput("pp_head_res4", cdbResult, 4);

        // push while full with no pop is discarded and flags overflow
        applyStimulus(4'd0, 32'd5, 32'd0, 3'd5);
        tick();
        applyStimulus(4'd0, 32'd6, 32'd0, 3'd6);
        tick();
        issueValid = 1'b0;
        #1;
        checkOutput("ovf_set", overflow, 1);
        checkOutput("ovf_head_rob4", cdbRob, 4);
        cdbGrant = 1'b1;
        tick();
        checkOutput("ovf_head_rob5", cdbRob, 5);
        tick();
        cdbGrant = 1'b0;
        #1;
        checkOutput("ovf_dropped", cdbReq, 0);
        checkOutput("ovf_sticky", overflow, 1);

        // flush with two entries buffered, grant and issue active
        applyStimulus(4'd0, 32'd10, 32'd0, 3'd1);
        tick();
        applyStimulus(4'd0, 32'd20, 32'd0, 3'd2);
        tick();
        applyStimulus(4'd0, 32'd30, 32'd0, 3'd3);
        cdbGrant = 1'b1;
        clear    = 1'b1;
        #1;
        checkOutput("clr_exec_low", execute, 0);
        tick();
        clear      = 1'b0;
        issueValid = 1'b0;
        cdbGrant   = 1'b0;
        #1;
        checkOutput("clr_req", cdbReq, 0);
        checkOutput("clr_rob", cdbRob, 0);
        checkOutput("clr_res", cdbResult, 0);
        checkOutput("clr_exec", execute, 1);
        checkOutput("clr_ovf", overflow, 0);
        tick();
        checkOutput("clr_empty", cdbReq, 0);

        // pointers restart cleanly after flush
        applyStimulus(4'd1, 32'd9, 32'd4, 3'd7);
        tick();
        issueValid = 1'b0;
        #1;
        checkOutput("post_req", cdbReq, 1);
        checkOutput("post_res", cdbResult, 32'd5);
        checkOutput("post_rob", cdbRob, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
